// File: rtl/serial_pair_tx.sv
// Serializes WIDTH-bit words MSB first and counts "11" pairs per word,
// including a pair that straddles two back-to-back words.
module serial_pair_tx #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic                       out,
  output logic                       out_valid,
  output logic [$clog2(WIDTH+1)-1:0] pair_count,
  output logic                       count_valid
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH-1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   idx;
  logic [WIDTH-1:0] sreg;
  logic            prev_bit;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            accept;
  logic            pair;

  // data_ready is gated by rst_n so it reads 0 for the whole reset window
  always_comb begin
    state_next = state;
    last       = (state == SHIFT) && (idx == LAST_IDX);
    data_ready = rst_n && ((state == IDLE) || last);
    accept     = data_valid && data_ready;
    pair       = out_valid && out && prev_bit;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      sreg        <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      prev_bit    <= 1'b0;
      cnt         <= '0;
      pair_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      prev_bit    <= out_valid && out;
      // cnt restarts on bit 0 so a straddling pair lands in the new word
      if (state == SHIFT) begin
        cnt <= ((idx == '0) ? '0 : cnt) + CW'(pair);
        if (last) begin
          pair_count  <= cnt + CW'(pair);
          count_valid <= 1'b1;
        end
      end
      if (accept) begin
        out       <= data_in[WIDTH-1];
        sreg      <= {data_in[WIDTH-2:0], 1'b0};
        out_valid <= 1'b1;
        idx       <= '0;
      end else if ((state == SHIFT) && !last) begin
        out       <= sreg[WIDTH-1];
        sreg      <= {sreg[WIDTH-2:0], 1'b0};
        idx       <= idx + IW'(1);
      end else begin
        out       <= 1'b0;
        out_valid <= 1'b0;
        idx       <= '0;
      end
    end
  end

endmodule
